// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the EX-stage multiply/divide unit.
//   MD_XLEN      default operand / HI / LO width
//   MD_*         op encodings presented on the op port (6-7 are no-ops)
//   md_state_e   sequencing FSM states
package md_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// md_datapath: iterative arithmetic core of the multiply/divide unit.
//   clk, reset       clock, synchronous active-high reset
//   load             capture operands, sign flags and mode
//   step             one shift-add (mult) or shift-subtract (div) iteration
//   is_div           selects divide mode at load
//   is_signed        treat operands as two's complement at load
//   data_s, data_t   rs / rt operands
//   res_hi, res_lo   sign-corrected result, valid after XLEN steps
import md_pkg::*;

module md_datapath #(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] data_s,
  input  logic [XLEN-1:0] data_t,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  // Accumulator: multiply holds {partial product, remaining multiplier},
  // divide holds {partial remainder, remaining dividend / quotient bits}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   orig_s;
  logic              div_mode;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;

  logic              sign_s, sign_t;
  logic [XLEN-1:0]   mag_s_in, mag_t_in;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign sign_s   = is_signed & data_s[XLEN-1];
  assign sign_t   = is_signed & data_t[XLEN-1];
  assign mag_s_in = sign_s ? -data_s : data_s;
  assign mag_t_in = sign_t ? -data_t : data_t;

  // Carry into bit XLEN of add_sum becomes the top bit after the right shift.
  assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
  // Remainder is always below the divisor, so bit XLEN of trial is a clean borrow.
  assign trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      mag_b    <= '0;
      orig_s   <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      acc      <= {{XLEN{1'b0}}, mag_s_in};
      mag_b    <= mag_t_in;
      orig_s   <= data_s;
      div_mode <= is_div;
      neg_res  <= sign_s ^ sign_t;
      neg_rem  <= sign_s;
      div_zero <= (data_t == '0);
    end else if (step) begin
      if (!div_mode) begin
        acc <= {add_sum, acc[XLEN-1:1]};
      end else if (!trial[XLEN]) begin
        acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc <= {acc[2*XLEN-2:0], 1'b0};
      end
    end
  end

  assign prod = neg_res ? -acc : acc;
  assign quo  = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  // Divide by zero bypasses the iteration result entirely. INT_MIN / -1 needs
  // no special case: its quotient magnitude negates back onto itself.
  always_comb begin
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (div_mode) begin
      if (div_zero) begin
        res_hi = orig_s;
        res_lo = '1;
      end else begin
        res_hi = neg_rem ? -rem : rem;
        res_lo = neg_res ? -quo : quo;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
//   clk, reset      clock, synchronous active-high reset
//   we, kill        stage advance enable, flush (abort / block issue)
//   start, op       mult/div/MT op present in EX and its encoding
//   mf_req          MFHI/MFLO present in EX
//   data_s, data_t  rs / rt operands
//   busy, stall     op in flight; pipeline must hold
//   done            result committed to HI/LO this cycle
//   hi, lo          architectural HI / LO registers
import md_pkg::*;

module ex_muldiv_unit #(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            kill,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            mf_req,
  input  logic [XLEN-1:0] data_s,
  input  logic [XLEN-1:0] data_t,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic            accept;
  logic            is_div_op, is_muldiv, is_signed_op, last_iter;
  logic            dp_load, dp_step;
  logic [XLEN-1:0] res_hi, res_lo;

  assign accept       = start & we & ~kill & (state == ST_IDLE);
  assign is_div_op    = (op == MD_DIV) | (op == MD_DIVU);
  assign is_muldiv    = (op == MD_MULT) | (op == MD_MULTU) | is_div_op;
  assign is_signed_op = (op == MD_MULT) | (op == MD_DIV);
  assign last_iter    = (cnt == CNT_W'(XLEN - 1));
  assign stall        = busy & (start | mf_req);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Kill aborts MUL/DIV but not FIX, so a result reaching FIX always commits.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_muldiv) begin
          dp_load  = 1'b1;
          state_nx = is_div_op ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        busy    = 1'b1;
        dp_step = 1'b1;
        if (kill)           state_nx = ST_IDLE;
        else if (last_iter) state_nx = ST_FIX;
      end
      ST_FIX: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || dp_load) cnt <= '0;
    else if (dp_step)     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (accept && op == MD_MTHI) begin
      hi <= data_s;
    end else if (accept && op == MD_MTLO) begin
      lo <= data_s;
    end
  end

  md_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (is_div_op),
    .is_signed (is_signed_op),
    .data_s    (data_s),
    .data_t    (data_t),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed bench for ex_muldiv_unit (XLEN=32 and XLEN=16).
import md_pkg::*;

module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, kill, start, mf_req;
  logic [2:0]  op;
  logic [31:0] data_s, data_t;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  logic        we16, kill16, start16, mf16;
  logic [2:0]  op16;
  logic [15:0] s16, t16;
  logic        busy16, stall16, done16;
  logic [15:0] hi16, lo16;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] s, t, hi, lo;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .we(we), .kill(kill), .start(start), .op(op),
    .mf_req(mf_req), .data_s(data_s), .data_t(data_t),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  ex_muldiv_unit #(.XLEN(16)) dut16 (
    .clk(clk), .reset(reset), .we(we16), .kill(kill16), .start(start16), .op(op16),
    .mf_req(mf16), .data_s(s16), .data_t(t16),
    .busy(busy16), .stall(stall16), .done(done16), .hi(hi16), .lo(lo16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; presents one op for one cycle, returns at posedge+1.
  task automatic applyStimulus(input logic [2:0] op_v, input logic [31:0] s, input logic [31:0] t);
    start  = 1'b1;
    we     = 1'b1;
    op     = op_v;
    data_s = s;
    data_t = t;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic waitDone(output int bc, output int dc);
    bc = 0;
    dc = 0;
    while (busy && bc < 200) begin
      if (done) dc++;
      bc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run16(input logic [2:0] op_v, input logic [15:0] s, input logic [15:0] t, output int bc);
    start16 = 1'b1;
    op16    = op_v;
    s16     = s;
    t16     = t;
    @(posedge clk); #1;
    start16 = 1'b0;
    bc = 0;
    while (busy16 && bc < 100) begin
      bc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int bc, dc, n, bad;
    logic [31:0] pre_hi, pre_lo;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[4] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
    vecs[7] = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9] = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};

    reset = 1'b1; we = 1'b1; kill = 1'b0; start = 1'b0; mf_req = 1'b0;
    op = 3'd0; data_s = '0; data_t = '0;
    we16 = 1'b1; kill16 = 1'b0; start16 = 1'b0; mf16 = 1'b0;
    op16 = 3'd0; s16 = '0; t16 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_stall", stall, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Arithmetic vectors: latency, single done pulse, hold during op, results.
    for (int i = 0; i < 10; i++) begin
      pre_hi = hi;
      applyStimulus(vecs[i].op, vecs[i].s, vecs[i].t);
      checkOutput($sformatf("v%0d_hold_hi", i), hi, pre_hi);
      waitDone(bc, dc);
      checkOutput($sformatf("v%0d_busy_cycles", i), bc, 33);
      checkOutput($sformatf("v%0d_done_pulses", i), dc, 1);
      checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].lo);
    end

    // we=0 and no-op encodings never issue.
    pre_hi = hi; pre_lo = lo;
    start = 1'b1; we = 1'b0; op = MD_MULT; data_s = 32'd3; data_t = 32'd3;
    @(posedge clk); #1;
    checkOutput("we0_no_issue", busy, 0);
    we = 1'b1; op = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("op6_no_issue", busy, 0);
    checkOutput("op6_hi", hi, pre_hi);
    checkOutput("op6_lo", lo, pre_lo);

    // Start and mf_req while busy: stall every busy cycle, issue once idle.
    applyStimulus(MD_MULT, 32'd3, 32'd5);
    start = 1'b1; op = MD_DIVU; data_s = 32'd100; data_t = 32'd7; mf_req = 1'b1;
    #1;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (!stall) bad++;
      n++;
      @(posedge clk); #1;
    end
    checkOutput("stall_missing", bad, 0);
    checkOutput("stall_busy_cycles", n, 33);
    checkOutput("stall_idle_stall", stall, 0);
    checkOutput("stall_mult_hi", hi, 0);
    checkOutput("stall_mult_lo", lo, 32'd15);
    @(posedge clk); #1;
    start = 1'b0; mf_req = 1'b0;
    checkOutput("held_op_issued", busy, 1);
    waitDone(bc, dc);
    checkOutput("held_busy_cycles", bc, 33);
    checkOutput("held_hi", hi, 32'd2);
    checkOutput("held_lo", lo, 32'd14);

    // MT writes: next-edge update, no busy.
    applyStimulus(MD_MTHI, 32'h1234, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mthi_lo", lo, 32'd14);
    checkOutput("mthi_busy", busy, 0);
    applyStimulus(MD_MTLO, 32'hABCD, 32'd0);
    checkOutput("mtlo_lo", lo, 32'hABCD);
    checkOutput("mtlo_hi", hi, 32'h1234);

    // Kill at iteration 10 of a DIV.
    applyStimulus(MD_DIV, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill_busy", busy, 0);
    checkOutput("kill_hi", hi, 32'h1234);
    checkOutput("kill_lo", lo, 32'hABCD);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    checkOutput("kill_no_done", dc, 0);
    checkOutput("kill_lo_later", lo, 32'hABCD);

    // Kill together with start while idle: no issue.
    kill = 1'b1;
    applyStimulus(MD_MTLO, 32'hDEAD, 32'd0);
    checkOutput("killstart_mt_lo", lo, 32'hABCD);
    applyStimulus(MD_MULT, 32'd2, 32'd2);
    checkOutput("killstart_mul_busy", busy, 0);
    kill = 1'b0;

    // Kill during FIX is ignored.
    applyStimulus(MD_DIVU, 32'd1000, 32'd3);
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("fixkill_cycles_to_fix", n, 32);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("fixkill_busy", busy, 0);
    checkOutput("fixkill_lo", lo, 32'h14D);
    checkOutput("fixkill_hi", hi, 32'd1);

    // Reset in the middle of a MULT.
    applyStimulus(MD_MULT, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_hi", hi, 0);
    checkOutput("midreset_lo", lo, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);

    // Narrow instance.
    run16(MD_MULTU, 16'hFFFF, 16'd2, bc);
    checkOutput("x16_mulu_busy", bc, 17);
    checkOutput("x16_mulu_hi", hi16, 16'h0001);
    checkOutput("x16_mulu_lo", lo16, 16'hFFFE);
    run16(MD_DIV, 16'hFFF9, 16'd2, bc);
    checkOutput("x16_div_busy", bc, 17);
    checkOutput("x16_div_hi", hi16, 16'hFFFF);
    checkOutput("x16_div_lo", lo16, 16'hFFFD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that sits beside the ALU in the EX stage. It executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers (MTHI/MTLO writes, MFHI/MFLO reads). A start/busy/stall handshake freezes the pipeline while a result is pending. The EX-stage kill aborts an in-flight operation on a flush.

Parameters:
XLEN, 32, operand/HI/LO width in bits (even, >= 8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
we  in  1  EX stage advance enable; an op issues only when we=1
kill  in  1  flush: abort in-flight op, block issue this cycle
start  in  1  EX holds a mult/div/MT op this cycle
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
mf_req  in  1  EX holds MFHI/MFLO and needs HI/LO
data_s  in  XLEN  rs operand (multiplicand/dividend/MT source)
data_t  in  XLEN  rt operand (multiplier/divisor)
busy  out  1  multi-cycle op in flight
stall  out  1  combinational: busy & (start | mf_req)
done  out  1  one-cycle pulse when HI/LO are updated by mult/div
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. The same applies when reset is asserted mid-operation; any in-flight op is discarded.
- Issue: `accept = start & we & ~kill & (state==IDLE)`. Operands and op are captured on accept. Ops 6-7 are ignored.
- MTHI/MTLO: on accept, hi (or lo) = data_s on the next edge. No busy, no done.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE->MUL on accepted op 0/1.
  - IDLE->DIV on accepted op 2/3.
  - MUL/DIV iterate exactly XLEN cycles, then go to FIX.
  - FIX->IDLE after 1 cycle.
- Datapath, signed ops: operate on magnitudes and record sign flags at accept.
- MUL: radix-2 shift-add, 2*XLEN-bit accumulator, one multiplier bit per cycle.
- DIV: restoring shift-subtract, one quotient bit per cycle.
- FIX: apply signs, write hi/lo, pulse done=1.
  - Product is negated if operand signs differ (full 2*XLEN result): HI = upper half, LO = lower half.
  - Quotient -> LO, negated if signs differ.
  - Remainder -> HI, taking the sign of the dividend.
- Latency: busy=1 from the cycle after accept through FIX inclusive (XLEN+1 cycles). done is high in the FIX cycle. Updated hi/lo are visible the cycle after FIX, when busy=0.
- Divide by zero: same latency. HI = original data_s, LO = all ones (signed and unsigned alike).
- Signed INT_MIN / -1: LO = INT_MIN, HI = 0 (no trap).
- hi/lo hold their old values during MUL/DIV and change only in FIX or on an MT write.
- Start while busy: not accepted. stall=1, so the pipeline holds and re-presents the op. It is accepted in the first IDLE cycle with we=1.
- mf_req while busy: stall=1 until busy falls. hi/lo read is combinational from the registers.
- kill while busy (any state except FIX): next state IDLE, busy=0 next cycle, hi/lo unchanged, no done.
- kill in the FIX cycle: ignored, so the result commits.
- kill and start in the same IDLE cycle: no issue.
- reset has priority over kill, which has priority over start.

Decomposition:
- Shared package md_pkg: op encodings (MD_MULT … MD_MTLO), FSM state enum, and the XLEN default constant.
- One sub-module is natural: md_datapath (accumulator/remainder registers, shift-add/subtract step, sign fix-up), driven by step/load/fix strobes.
- The top level keeps the FSM, counter, handshake, and HI/LO registers.

Test Plan:
1. MULT data_s=0xFFFFFFFD (-3), data_t=7 -> busy for 33 cycles, done pulse, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT on the same operands -> hi=0, lo=1.
3. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 5 / 0 -> hi=5, lo=0xFFFFFFFF, same 33-cycle busy. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Issue MULT, then hold start=1 (DIVU) and mf_req=1 -> stall=1 on every busy cycle. DIVU is accepted in the cycle after busy falls. MTHI 0x1234 while idle -> hi=0x1234 next cycle, busy stays 0.
5. DIV in flight, kill at iteration 10 -> busy=0 next cycle, hi/lo equal pre-op values, done never pulses. kill asserted in the FIX cycle -> result commits.
6. Reset asserted mid-MULT -> next cycle hi=lo=0, busy=0, done=0. With XLEN=16, MULTU 0xFFFF x 2 -> hi=0x0001, lo=0xFFFE, busy for 17 cycles.
